vec_accum: RTL
==============

VEC_ACCUM -- requirements
Module: vec_accum

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width of a queue word (signed two's complement).
REQ-002 Parameter EXTRA_BITS, default 2, tag bits above the payload: bit DATA_WIDTH = SOV (start of vector), bit DATA_WIDTH+1 = EOV (end of vector).
REQ-003 Parameter ADDRESS_WIDTH, default 1; RAM_DEPTH = 1<<ADDRESS_WIDTH, the depth of the upstream queue.
REQ-004 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 mem_wr_en  in  1  copy of the upstream queue write enable, used only for occupancy tracking.
REQ-007 mem_rd_en  out  1  read enable to the upstream queue.
REQ-008 mem_data  in  DATA_WIDTH+EXTRA_BITS  queue read data, valid the cycle after mem_rd_en.
REQ-009 sum_out  out  DATA_WIDTH  saturated vector sum.
REQ-010 sum_valid  out  1  sum_out holds a completed vector result.
REQ-011 sum_ready  in  1  downstream accepts result when high with sum_valid.
REQ-012 sum_ovf  out  1  saturation occurred within the vector reported by sum_out.

Function
REQ-013 Occupancy counter cnt (0..RAM_DEPTH) SHALL increment on mem_wr_en alone, decrement on mem_rd_en alone, hold when both or neither are asserted.
REQ-014 cnt SHALL saturate at RAM_DEPTH on a write while full and SHALL NOT underflow below 0.
REQ-015 FSM states: S_IDLE, S_FETCH, S_OUT.
REQ-016 S_IDLE: if cnt>0, assert mem_rd_en for exactly one cycle and go to S_FETCH; else stay.
REQ-017 S_FETCH: capture mem_data (one-cycle read latency); if SOV, acc = payload, else acc = acc + payload; then go to S_OUT if EOV, else S_IDLE.
REQ-018 At most one read outstanding; mem_rd_en SHALL never be asserted outside S_IDLE; peak throughput one word per 2 cycles.
REQ-019 Addition SHALL be signed DATA_WIDTH; on overflow acc clamps to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1), and a sticky ovf bit sets; SOV clears ovf before the add.
REQ-020 SOV and EOV both set: single-term vector, sum_out = payload.
REQ-021 S_OUT: sum_valid=1, sum_out=acc, sum_ovf=ovf, all stable until sum_valid && sum_ready.
REQ-022 On handshake: return to S_IDLE, clear acc and ovf, and deassert sum_valid the next cycle; no read is issued in the handshake cycle.
REQ-023 A word without SOV following a completed vector SHALL accumulate onto the cleared acc (zero).
REQ-024 mem_wr_en during S_FETCH/S_OUT SHALL still update cnt; no words are lost.

Reset
REQ-025 With rst low at a clock edge: state=S_IDLE, cnt=0, acc=0, ovf=0, mem_rd_en=0, sum_out=0, sum_valid=0, sum_ovf=0.
REQ-026 Reset mid-vector or mid-handshake SHALL discard the partial sum and pending result; the upstream queue is reset from the same rst.

Structure
REQ-027 Shared package: DATA_WIDTH, EXTRA_BITS, tag bit positions SOV_BIT/EOV_BIT, FSM state encoding, saturation limit constants.
REQ-028 One sub-module, sat_add: combinational signed DATA_WIDTH adder with clamp and overflow flag.
REQ-029 Bench instantiates vec_accum with the upstream queue, mem_wr_en wired to both.

Verification
REQ-030 Write {SOV,5},{-,7},{EOV,-2}, sum_ready=1 -> sum_out=10, sum_valid one cycle, sum_ovf=0.
REQ-031 Write {SOV|EOV,0x7FFF0000} -> sum_out=0x7FFF0000, single result.
REQ-032 Write {SOV,0x7FFFFFFF},{EOV,1} -> sum_out=0x7FFFFFFF, sum_ovf=1; next vector {SOV|EOV,3} -> 3, sum_ovf=0.
REQ-033 Hold sum_ready=0 for 10 cycles with words queued -> sum_out stable, no mem_rd_en until handshake; next vector correct.
REQ-034 Assert rst low after two words of a four-word vector -> all outputs 0, cnt=0; fresh vector {SOV,1},{EOV,2} -> 3.
REQ-035 Write and read in same cycle with cnt=1 -> cnt stays 1; writes with cnt=RAM_DEPTH -> cnt stays RAM_DEPTH.

Source files
------------

// File: rtl/vec_accum_pkg.sv
// Shared constants and types for the vector accumulator: default widths,
// tag bit positions, FSM encoding and saturation limits.
package vec_accum_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int EXTRA_BITS = 2;

    // Tag offsets above the payload; absolute positions for the default width.
    localparam int SOV_OFS = 0;
    localparam int EOV_OFS = 1;
    localparam int SOV_BIT = DATA_WIDTH + SOV_OFS;
    localparam int EOV_BIT = DATA_WIDTH + EOV_OFS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/vec_accum_sat_add.sv
// Combinational signed adder that clamps to the representable range and
// flags whenever clamping took place.
module vec_accum_sat_add #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_ovf
);

    localparam logic [DATA_WIDTH-1:0] LIM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] LIM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Result carries one guard bit; guard != sign means the true sum left the range.
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [DATA_WIDTH:0] x);
        if (x[DATA_WIDTH] != x[DATA_WIDTH-1])
            return {1'b1, (x[DATA_WIDTH] ? LIM_MIN : LIM_MAX)};
        return {1'b0, x[DATA_WIDTH-1:0]};
    endfunction

    logic signed [DATA_WIDTH:0] w_wide;

    assign w_wide = $signed({i_a[DATA_WIDTH-1], i_a}) + $signed({i_b[DATA_WIDTH-1], i_b});
    assign {o_ovf, o_sum} = saturate(w_wide);

endmodule

// File: rtl/vec_accum.sv
// Pulls tagged words from an upstream queue one at a time, accumulates each
// SOV..EOV vector with saturation and holds the result until accepted.
module vec_accum #(
    parameter int DATA_WIDTH    = vec_accum_pkg::DATA_WIDTH,
    parameter int EXTRA_BITS    = vec_accum_pkg::EXTRA_BITS,
    parameter int ADDRESS_WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_wr_en,
    output logic                             mem_rd_en,
    input  logic [DATA_WIDTH+EXTRA_BITS-1:0] mem_data,
    output logic [DATA_WIDTH-1:0]            sum_out,
    output logic                             sum_valid,
    input  logic                             sum_ready,
    output logic                             sum_ovf
);
    import vec_accum_pkg::*;

    localparam int                   RAM_DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] CNT_FULL = RAM_DEPTH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] CNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDRESS_WIDTH:0]  r_cnt;
    logic signed [DATA_WIDTH-1:0] r_acc;
    logic                    r_ovf;
    logic                    w_rd_en;
    logic [DATA_WIDTH-1:0]   w_payload;
    logic                    w_sov;
    logic                    w_eov;
    logic [DATA_WIDTH-1:0]   w_add_sum;
    logic                    w_add_ovf;

    assign w_payload = mem_data[DATA_WIDTH-1:0];
    assign w_sov     = mem_data[DATA_WIDTH + SOV_OFS];
    assign w_eov     = mem_data[DATA_WIDTH + EOV_OFS];

    vec_accum_sat_add #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_payload),
        .o_sum (w_add_sum),
        .o_ovf (w_add_ovf)
    );

    // Occupancy mirror of the upstream queue, clamped to [0, RAM_DEPTH].
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (mem_wr_en && !w_rd_en) begin
            if (r_cnt != CNT_FULL)
                r_cnt <= r_cnt + CNT_ONE;
        end else if (w_rd_en && !mem_wr_en) begin
            if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cnt != '0) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = w_eov ? S_OUT : S_IDLE;
            S_OUT:   if (sum_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Accumulator: SOV restarts the vector, handshake clears for the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == S_FETCH) begin
            if (w_sov) begin
                r_acc <= w_payload;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_add_sum;
                r_ovf <= r_ovf | w_add_ovf;
            end
        end else if (r_state == S_OUT && sum_ready) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end
    end

    assign mem_rd_en = w_rd_en;
    assign sum_valid = (r_state == S_OUT);
    assign sum_out   = r_acc;
    assign sum_ovf   = r_ovf;

endmodule
